// File: rtl/spi_tx_buffer.sv
// SPI slave transmit buffer: one-byte holding register feeding an MSB-first
// shift register clocked by the SPI serial clock; shifts FILL when starved.
module spi_tx_buffer #(
    parameter logic [7:0] FILL = 8'hFF
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       CS,
    input  logic       IsInitialized,
    input  logic [7:0] TxData,
    input  logic       TxValid,
    output logic       TxReady,
    input  logic       ClearUnderflow,
    output logic       DO,
    output logic       Sent,
    output logic       Underflow
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] hold;
    logic              hold_full;
    logic [DATA_W-1:0] shreg;
    logic              sh_valid;
    logic [CNT_W-1:0]  counter;
    logic              sent_q;
    logic              underflow_q;

    logic accept;
    logic byte_end;
    logic reload;
    logic underflow_set;

    assign TxReady   = ~hold_full;
    assign DO        = CS ? 1'b1 : shreg[DATA_W-1];
    assign Sent      = sent_q;
    assign Underflow = underflow_q;

    // Edge decisions, all from pre-edge state.
    always_comb begin
        accept        = TxValid & ~hold_full;
        byte_end      = ~CS & (counter == LAST_BIT);
        underflow_set = ~CS & (counter == '0) & ~sh_valid;
        reload        = 1'b0;
        if (CS) begin
            // A deselect mid-byte drops the partial byte; an idle FILL keeps polling the holding register.
            reload = (counter != '0) | ~sh_valid;
        end else begin
            reload = byte_end;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            counter     <= '0;
            shreg       <= FILL;
            sh_valid    <= 1'b0;
            hold        <= '0;
            hold_full   <= 1'b0;
            sent_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else if (!IsInitialized) begin
            counter     <= '0;
            shreg       <= FILL;
            sh_valid    <= 1'b0;
            hold_full   <= 1'b0;
            sent_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sent_q <= byte_end & sh_valid;

            if (CS || byte_end) begin
                counter <= '0;
            end else begin
                counter <= counter + CNT_W'(1);
                shreg   <= {shreg[DATA_W-2:0], 1'b1};
            end

            if (reload) begin
                if (hold_full) begin
                    shreg    <= hold;
                    sh_valid <= 1'b1;
                end else begin
                    shreg    <= FILL;
                    sh_valid <= 1'b0;
                end
            end

            // accept needs an empty holding register, so it never collides with a reload from it.
            if (accept) begin
                hold      <= TxData;
                hold_full <= 1'b1;
            end else if (reload) begin
                hold_full <= 1'b0;
            end

            if (underflow_set) begin
                underflow_q <= 1'b1;
            end else if (ClearUnderflow) begin
                underflow_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_tx_buffer.sv
// Randomized and directed bench for spi_tx_buffer against a frame-level model
// (byte queue plus bit position within the current frame).
module tb_spi_tx_buffer;

    localparam logic [7:0] FILL = 8'hFF;

    logic       CLK = 1'b0;
    logic       reset;
    logic       CS;
    logic       IsInitialized;
    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady;
    logic       ClearUnderflow;
    logic       DO;
    logic       Sent;
    logic       Underflow;

    spi_tx_buffer #(.FILL(FILL)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .CS             (CS),
        .IsInitialized  (IsInitialized),
        .TxData         (TxData),
        .TxValid        (TxValid),
        .TxReady        (TxReady),
        .ClearUnderflow (ClearUnderflow),
        .DO             (DO),
        .Sent           (Sent),
        .Underflow      (Underflow)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Frame-level model: pending bytes waiting, byte in flight, bits already clocked out.
    logic [7:0] m_pending[$];
    logic [7:0] m_frame;
    bit         m_frame_real;
    int         m_bits_done;
    bit         m_sent;
    bit         m_uf;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending.delete();
        m_frame      = FILL;
        m_frame_real = 1'b0;
        m_bits_done  = 0;
        m_sent       = 1'b0;
        m_uf         = 1'b0;
    endtask

    function automatic logic exp_do();
        logic [7:0] f;
        f = m_frame;
        return CS ? 1'b1 : f[7 - m_bits_done];
    endfunction

    // Advance the model by one CLK rising edge using the inputs seen at that edge.
    task automatic model_step();
        bit take, next_frame, starve;
        if (!reset) begin
            model_reset();
            return;
        end
        if (!IsInitialized) begin
            model_reset();
            return;
        end
        take       = TxValid && (m_pending.size() == 0);
        starve     = !CS && (m_bits_done == 0) && !m_frame_real;
        next_frame = 1'b0;
        m_sent     = 1'b0;
        if (CS) begin
            next_frame  = (m_bits_done != 0) || !m_frame_real;
            m_bits_done = 0;
        end else if (m_bits_done < 7) begin
            m_bits_done++;
        end else begin
            m_bits_done = 0;
            m_sent      = m_frame_real;
            next_frame  = 1'b1;
        end
        if (next_frame) begin
            if (m_pending.size() != 0) begin
                m_frame      = m_pending.pop_front();
                m_frame_real = 1'b1;
            end else begin
                m_frame      = FILL;
                m_frame_real = 1'b0;
            end
        end
        if (take) m_pending.push_back(TxData);
        if (starve) m_uf = 1'b1;
        else if (ClearUnderflow) m_uf = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".DO"},        8'(DO),        8'(exp_do()));
        check({tag, ".TxReady"},   8'(TxReady),   8'(m_pending.size() == 0));
        check({tag, ".Sent"},      8'(Sent),      8'(m_sent));
        check({tag, ".Underflow"}, 8'(Underflow), 8'(m_uf));
    endtask

    task automatic cycle(input string tag);
        @(posedge CLK);
        model_step();
        #1;
        check_all(tag);
    endtask

    // Shift one frame with CS low, collecting DO before each edge.
    task automatic shift_byte(input string tag, output logic [7:0] b);
        b  = '0;
        CS = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            b = {b[6:0], DO};
            cycle(tag);
            TxValid = 1'b0;
        end
    endtask

    task automatic queue_and_load(input logic [7:0] d);
        CS = 1'b1; TxData = d; TxValid = 1'b1;
        cycle("queue");
        TxValid = 1'b0;
        cycle("load");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         sent_cnt;
        reset = 1'b0; CS = 1'b1; IsInitialized = 1'b1;
        TxData = '0; TxValid = 1'b0; ClearUnderflow = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        #10 reset = 1'b1;

        // A5 via holding register.
        queue_and_load(8'hA5);
        shift_byte("a5", b);
        check("a5.byte", b, 8'hA5);
        check("a5.sent", 8'(Sent), 8'd1);
        check("a5.uf", 8'(Underflow), 8'd0);

        // 3C then C3 queued while 3C shifts.
        queue_and_load(8'h3C);
        TxData = 8'hC3; TxValid = 1'b1;
        shift_byte("b1", b);
        check("b1.byte", b, 8'h3C);
        shift_byte("b2", b);
        check("b2.byte", b, 8'hC3);

        // Starved frame.
        CS = 1'b1; cycle("idle");
        shift_byte("fill", b);
        check("fill.byte", b, FILL);
        check("fill.uf", 8'(Underflow), 8'd1);
        CS = 1'b1; ClearUnderflow = 1'b1;
        cycle("clr");
        ClearUnderflow = 1'b0;
        check("clr.uf", 8'(Underflow), 8'd0);

        // Deselect mid-byte with next byte waiting.
        queue_and_load(8'hF0);
        CS = 1'b0; TxData = 8'h81; TxValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("part");
            TxValid = 1'b0;
        end
        CS = 1'b1; cycle("abort");
        check("abort.sent", 8'(Sent), 8'd0);
        shift_byte("after", b);
        check("after.byte", b, 8'h81);

        // Async reset between edges mid-byte.
        queue_and_load(8'h5A);
        CS = 1'b0;
        for (int i = 0; i < 3; i++) cycle("pre_rst");
        #2 reset = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        check("async_rst.do", 8'(DO), 8'(FILL[7]));
        #2 reset = 1'b1;

        // Synchronous clear with hold full and Underflow set.
        CS = 1'b0; cycle("uf_set");
        CS = 1'b1; TxData = 8'h42; TxValid = 1'b1; cycle("fillhold");
        TxValid = 1'b0;
        check("pre_clr.ready", 8'(TxReady), 8'd0);
        check("pre_clr.uf", 8'(Underflow), 8'd1);
        IsInitialized = 1'b0; cycle("deinit");
        IsInitialized = 1'b1;
        check("deinit.ready", 8'(TxReady), 8'd1);
        check("deinit.uf", 8'(Underflow), 8'd0);
        shift_byte("post_clr", b);
        check("post_clr.byte", b, FILL);

        // Randomized traffic.
        sent_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            CS             = ($urandom_range(0, 9) == 0);
            TxValid        = $urandom_range(0, 2) != 0;
            TxData         = 8'($urandom);
            ClearUnderflow = ($urandom_range(0, 15) == 0);
            IsInitialized  = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b0;
                #1 model_reset();
                check_all("rnd_rst");
                #1 reset = 1'b1;
            end
            cycle("rnd");
            if (Sent) sent_cnt++;
        end
        check("rnd.activity", 8'(sent_cnt > 0), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
